// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a byte FIFO feeding the console uart char_in/read inputs.
// Optional even-parity framing (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          char_busy,
  output logic [7:0]                    char_in,
  output logic                          read,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state, state_nxt;
  logic                     rx_p0, rx_s, rx_s_p1;
  logic [15:0]              bit_cnt;
  logic [2:0]               bit_idx;
  logic signed [DATA_W-1:0] shift_p0;
  logic                     expire;
  logic                     cnt_ld, bit_clr, shift_en, push, stop_bad;
  logic [15:0]              cnt_ld_val;
`ifdef UART_RX_PARITY_EN
  logic                     par_bad_r, par_sample, par_flag;
`endif

  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     pop, full, wr_en, ovr;

  // Stage p0/p1: two-flop synchronizer, then one more flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_p1 <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_s    <= rx_p0;
      rx_s_p1 <= rx_s;
    end
  end

  assign expire = (bit_cnt == 16'd1);

  always_comb begin
    state_nxt  = state;
    cnt_ld     = 1'b0;
    cnt_ld_val = FULL_BIT;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
    par_flag   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_s_p1 && !rx_s) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = HALF_BIT;
          state_nxt  = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            cnt_ld    = 1'b1;
            bit_clr   = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en = 1'b1;
          cnt_ld   = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          par_sample = 1'b1;
          cnt_ld     = 1'b1;
          state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          state_nxt = IDLE;
          stop_bad  = !rx_s;
`ifdef UART_RX_PARITY_EN
          par_flag  = par_bad_r;
          push      = rx_s && !par_bad_r;
`else
          push      = rx_s;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      state <= state_nxt;
      if (cnt_ld)
        bit_cnt <= cnt_ld_val;
      else if (bit_cnt > 16'd1)
        bit_cnt <= bit_cnt - 16'd1;
      if (bit_clr)
        bit_idx <= 3'd0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Data path: LSB-first deserializer, no reset needed
  always_ff @(posedge clk) begin
    if (shift_en)
      shift_p0 <= {rx_s, shift_p0[DATA_W-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data ones plus the parity bit must sum to an even number
  always_ff @(posedge clk) begin
    if (reset)
      par_bad_r <= 1'b0;
    else if (par_sample)
      par_bad_r <= (^shift_p0) ^ rx_s;
  end
`endif

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
  assign pop   = (count != '0) && !char_busy;
  assign full  = (count == DEPTH_C);
  assign wr_en = push && (!full || pop);
  assign ovr   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= shift_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read       <= 1'b0;
      char_in    <= 8'h00;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      read      <= pop;
      frame_err <= stop_bad;
      overrun   <= ovr;
`ifdef UART_RX_PARITY_EN
      parity_err <= par_flag;
`endif
      if (pop) begin
        char_in <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a frame-level byte/flag model.
module tb_uart_rx_fifo;

  localparam int BAUD  = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       char_busy;
  logic [7:0] char_in;
  logic       read;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .char_busy(char_busy),
    .char_in(char_in), .read(read), .fifo_count(fifo_count),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        n_ferr  = 0;
  int        n_ovr   = 0;
  int        n_perr  = 0;
  logic [7:0] got_q[$];
  int        rd_cyc[$];
  logic [7:0] exp_q[$];
  int        got_rd = 0;
  bit        rnd_busy = 0;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (read) begin
        got_q.push_back(char_in);
        rd_cyc.push_back(cyc);
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr <= n_perr + 1;
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_busy) char_busy = 1'($urandom % 2);
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  // One serial frame; stop_ok=0 drives a low stop bit, par_ok=0 inverts the parity bit
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    rx = 1'b0;
    hold(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BAUD);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ !par_ok;
    hold(BAUD);
`endif
    rx = stop_ok;
    hold(BAUD);
    rx = 1'b1;
  endtask

  task automatic compare_bytes(input string tag);
    check_eq({tag, "_n"}, got_q.size() - got_rd, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++)
      check_eq({tag, "_byte"}, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ferr0, ovr0, perr0, nb_bad, first;
    logic [7:0] b;
    bit ok;
    reset = 1'b1; rx = 1'b1; char_busy = 1'b0;
    hold(3);
    check_eq("rst_char_in", char_in, 8'h00);
    check_eq("rst_read", read, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_ovr", overrun, 0);
    reset = 1'b0;
    hold(5);

    // Single byte
    ferr0 = n_ferr; ovr0 = n_ovr;
    send_frame(8'hA5, 1, 1);
    hold(40);
    exp_q.push_back(8'hA5);
    compare_bytes("single");
    check_eq("single_count", fifo_count, 0);
    check_eq("single_ferr", n_ferr - ferr0, 0);
    check_eq("single_ovr", n_ovr - ovr0, 0);

    // Glitch then a valid frame
    ferr0 = n_ferr;
    rx = 1'b0; hold(4); rx = 1'b1; hold(40);
    check_eq("glitch_reads", got_q.size() - got_rd, 0);
    send_frame(8'h3C, 1, 1);
    hold(40);
    exp_q.push_back(8'h3C);
    compare_bytes("glitch");
    check_eq("glitch_ferr", n_ferr - ferr0, 0);

    // Framing error, then recovery
    ferr0 = n_ferr;
    send_frame(8'h55, 0, 1);
    hold(40);
    check_eq("ferr_pulse", n_ferr - ferr0, 1);
    check_eq("ferr_reads", got_q.size() - got_rd, 0);
    send_frame(8'h01, 1, 1);
    hold(40);
    exp_q.push_back(8'h01);
    compare_bytes("ferr_next");

    // Overrun: hold the consumer off while DEPTH+1 bytes arrive
    ovr0 = n_ovr;
    char_busy = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1, 1);
      hold(3);
    end
    hold(20);
    check_eq("ovr_count", fifo_count, DEPTH);
    check_eq("ovr_pulse", n_ovr - ovr0, 1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i));
    first = got_rd;
    char_busy = 1'b0;
    hold(30);
    if (got_q.size() >= first + DEPTH)
      check_eq("ovr_b2b", rd_cyc[first + DEPTH - 1] - rd_cyc[first], DEPTH - 1);
    compare_bytes("ovr");
    check_eq("ovr_drained", fifo_count, 0);

    // Reset mid-frame with two bytes buffered
    char_busy = 1'b1;
    send_frame(8'h11, 1, 1); hold(3);
    send_frame(8'h22, 1, 1); hold(20);
    check_eq("pre_rst_count", fifo_count, 2);
    rx = 1'b0; hold(BAUD);
    rx = 1'b1; hold(4 * BAUD + BAUD / 2);
    reset = 1'b1;
    hold(1);
    check_eq("mid_rst_char_in", char_in, 8'h00);
    check_eq("mid_rst_read", read, 0);
    check_eq("mid_rst_count", fifo_count, 0);
    check_eq("mid_rst_ferr", frame_err, 0);
    check_eq("mid_rst_ovr", overrun, 0);
    reset = 1'b0;
    hold(6 * BAUD);
    char_busy = 1'b0;
    hold(20);
    check_eq("post_rst_reads", got_q.size() - got_rd, 0);
    send_frame(8'h81, 1, 1);
    hold(40);
    exp_q.push_back(8'h81);
    compare_bytes("post_rst");

`ifdef UART_RX_PARITY_EN
    perr0 = n_perr;
    send_frame(8'h07, 1, 0);
    hold(40);
    check_eq("par_bad_pulse", n_perr - perr0, 1);
    check_eq("par_bad_reads", got_q.size() - got_rd, 0);
    send_frame(8'h07, 1, 1);
    hold(40);
    exp_q.push_back(8'h07);
    compare_bytes("par_good");
`endif

    // Random frames with a randomly stalling consumer
    ferr0 = n_ferr; ovr0 = n_ovr; perr0 = n_perr; nb_bad = 0;
    rnd_busy = 1;
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      ok = ($urandom % 8) != 0;
      send_frame(b, ok, 1);
      if (ok) exp_q.push_back(b);
      else nb_bad++;
      hold(1 + $urandom % 20);
    end
    rnd_busy = 0;
    char_busy = 1'b0;
    hold(60);
    compare_bytes("rand");
    check_eq("rand_ferr", n_ferr - ferr0, nb_bad);
    check_eq("rand_ovr", n_ovr - ovr0, 0);
    check_eq("rand_perr", n_perr - perr0, 0);
    check_eq("rand_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the console UART. Samples the asynchronous `rx` line and deserializes 8N1 frames. Received bytes are buffered in a small FIFO and handed to the console `uart` block over its `char_in`/`read` inputs, which are currently tied off in the SoC top. Flags framing errors and overruns so the host can count them.

## Interface
- `BAUD_DIV`, 434: clock cycles per bit (≥ 4, 16 bits wide); 434 is 115200 baud at 50 MHz
- `FIFO_DEPTH`, 8: byte buffer entries; power of two, 2..64
- `clk`  in  1  system clock
- `reset`  in  1  reset: one clock, synchronous, active-high
- `rx`  in  1  asynchronous serial input; idle high
- `char_busy`  in  1  consumer stall; when high, no byte is delivered (tie 0 if unused)
- `char_in`  out  8  delivered byte; valid only while `read` is high
- `read`  out  1  one-cycle delivery strobe; drives console `uart.read`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: byte completed while FIFO full

## Operation
- Input synchronizer:
  - `rx` passes through a 2-flop synchronizer to form `rx_s`.
  - Both flops reset to 1.
- Receive state machine states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_s` 1→0, load the bit counter with `BAUD_DIV/2` (integer divide) and go to START.
  - START: when the counter expires, sample `rx_s`.
    - Low: reload the counter with `BAUD_DIV`, clear the bit index, go to DATA.
    - High: false start; return to IDLE with no flags.
  - DATA: at each expiry, shift `rx_s` into the shift register LSB-first and reload `BAUD_DIV`. After bit index 7, go to STOP.
  - STOP: at expiry, sample `rx_s`.
    - High: push the byte to the FIFO.
    - Low: discard the byte and pulse `frame_err`.
    - Either way, return to IDLE. IDLE re-arms on the next falling edge; a low line after a framing error is not a new start until it goes high and falls again.
- Counter: down-counter; "expiry" is the cycle the counter reads 1.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo depth. A separate count register disambiguates full from empty.
  - Push when full: byte dropped, `overrun` pulses, buffered contents untouched.
- Delivery:
  - When count > 0 and `char_busy` = 0, assert `read` for one cycle with `char_in` = head byte, then pop.
  - Back-to-back strobes are allowed on consecutive cycles.
  - `char_in` is held at the last delivered value when `read` is low.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. Legal even when full; the pop frees the slot and no overrun is flagged.
- Reset:
  - Reset asserted mid-frame aborts the frame.
  - State returns to IDLE, FIFO is emptied, pointers and count go to 0.
  - Reset values: `char_in` = 0x00, `read` = 0, `fifo_count` = 0, `frame_err` = 0, `overrun` = 0.

## Timing
- Start detection: a falling edge on `rx` is seen in IDLE 2 cycles later (synchronizer).
- Data bit k is sampled `BAUD_DIV/2 + (k+1)·BAUD_DIV` cycles after detection. The stop bit is sampled at `BAUD_DIV/2 + 9·BAUD_DIV`.
- Push: the byte enters the FIFO on the clock edge following the stop-bit sample; `fifo_count` increments in that cycle.
- Delivery latency: `read` asserts at the earliest one cycle after the push when the FIFO was empty and `char_busy` = 0.
- `frame_err` and `overrun` are registered and asserted in the cycle after the stop-bit sample.
- `char_busy` is sampled combinationally in the delivery decision. A stall seen in cycle N suppresses `read` in cycle N+1.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples a ninth bit; the stop sample moves to `BAUD_DIV/2 + 10·BAUD_DIV`.
  - Even parity: on mismatch, the byte is discarded and an extra output `parity_err` (1 bit, reset 0) pulses with the same timing as `frame_err`.
  - If both parity and stop bit are bad, both pulses fire.
- Undefined: 8N1 only; the `parity_err` port does not exist.

## Test plan
- Single byte: `BAUD_DIV`=16, send 0xA5 8N1 → exactly one `read` pulse with `char_in`=0xA5; `fifo_count` returns to 0; no error pulses.
- Glitch: `rx` low for 4 cycles then high (`BAUD_DIV`=16) → false start, no `read`, no `frame_err`, next frame 0x3C received correctly.
- Framing error: send 0x55 with the stop bit driven low → one `frame_err` pulse; no `read`; the following frame 0x01 is delivered after `rx` returns high.
- Overrun: `char_busy`=1, `FIFO_DEPTH`=8, send 9 bytes 0x00..0x08 → `fifo_count`=8 and one `overrun` pulse on the 9th. Releasing `char_busy` gives 8 consecutive `read` pulses delivering 0x00..0x07.
- Reset mid-frame: assert `reset` during data bit 4 of frame 0xFF with 2 bytes buffered → all outputs at reset values, `fifo_count`=0. The next full frame 0x81 is delivered.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` pulse, no `read`. Send 0x07 with parity bit 1 → `read` with 0x07.
